// File: rtl/fprint_mem_pkg.sv
// Shared types and defaults for the fingerprint memory copy master.
// The state enum, default bus widths and the all-ones byteenable constant live here.
package fprint_mem_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W_DEF   = DATA_W_DEF / 8;

    localparam logic [BE_W_DEF-1:0] BE_ALL_ONES = {BE_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM master copying a block of words read/write-alternately through a
// single-port memory, accumulating an additive checksum of every word read.
module onchip_memory_copy_master
    import fprint_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W-1:0]     len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [DATA_W-1:0]     checksum,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_waitrequest
);

    state_e              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   sum_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic                rd_q;
    logic                wr_q;

    logic [ADDR_W-1:0]   idx_inc_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic                last_word_d;

    // Index increment and wrapped word addresses used by the FSM
    always_comb begin
        idx_inc_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        rd_addr_d   = src_q + idx_inc_d;
        wr_addr_d   = dst_q + idx_q;
        last_word_d = (idx_inc_d == len_q);
    end

    // Copy FSM; every bus and status output is a register updated here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            src_q     <= {ADDR_W{1'b0}};
            dst_q     <= {ADDR_W{1'b0}};
            len_q     <= {ADDR_W{1'b0}};
            idx_q     <= {ADDR_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            data_q    <= {DATA_W{1'b0}};
            sum_q     <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        len_q     <= len_words;
                        idx_q     <= {ADDR_W{1'b0}};
                        sum_q     <= {DATA_W{1'b0}};
                        aborted_q <= 1'b0;
                        if (len_words != {ADDR_W{1'b0}}) begin
                            state_q <= ST_RD;
                            busy_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr;
                        end else begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (!avm_waitrequest) begin
                        rd_q    <= 1'b0;
                        state_q <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    // Read data is valid exactly one cycle after the read was accepted
                    data_q  <= avm_readdata;
                    sum_q   <= sum_q + avm_readdata;
                    wr_q    <= 1'b1;
                    addr_q  <= wr_addr_d;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    if (!avm_waitrequest) begin
                        wr_q  <= 1'b0;
                        idx_q <= idx_inc_d;
                        if (last_word_d) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (abort) begin
                            state_q   <= ST_FIN;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            aborted_q <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            rd_q    <= 1'b1;
                            addr_q  <= rd_addr_d;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign checksum       = sum_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = {(DATA_W/8){1'b1}};

endmodule
